hub75_frame_buffer: RTL and testbench
=====================================

Name: hub75_frame_buffer

Overview:
- Parametrised, double-buffered framebuffer for a HUB75 split-scan LED panel.
- The producer (physics renderer) writes pixels into the back bank through a valid/ready port.
- The panel scanner reads the front bank as top/bottom half pairs and gets BCM bit-plane outputs one cycle later.
- Adds bank swap at frame boundaries and a hardware clear engine.

Parameters:
- PANEL_W, 64, panel width in pixels; power of 2, ≥ 2.
- PANEL_H, 64, panel height in pixels; power of 2, ≥ 4; top half = rows 0..PANEL_H/2-1.
- COLOR_BITS, 3, bits per channel (1..8).
- Derived: XW=$clog2(PANEL_W), YW=$clog2(PANEL_H), PW=$clog2(COLOR_BITS+1), CW=3*COLOR_BITS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_x  in  XW  write column.
- wr_y  in  YW  write row (MSB selects bottom half).
- wr_color  in  CW  {r,g,b}, r in MSBs.
- clear_req  in  1  pulse: fill back bank with clear_color.
- clear_color  in  CW  fill colour, latched at clear start.
- clear_busy  out  1  clear engine running.
- swap_req  in  1  pulse: request front/back exchange.
- swap_pending  out  1  swap requested, not yet applied.
- front_bank  out  1  bank currently displayed.
- frame_start  in  1  scanner pulse at start of each frame.
- rd_en  in  1  read front bank at rd_row/rd_col.
- rd_row  in  YW-1  scan row (both halves).
- rd_col  in  XW  scan column.
- bcm_phase  in  PW  bit-plane index.
- rd_valid  out  1  R1..B2 valid.
- R1, G1, B1  out  1 each  top-half bit-plane outputs.
- R2, G2, B2  out  1 each  bottom-half bit-plane outputs.

Behaviour:
- Storage:
  - Four behavioural RAMs (bank0/1 × top/bottom), each PANEL_W*PANEL_H/2 words of CW bits.
  - Address is {row, col}; reads are registered with 1-cycle latency.
  - Contents are not reset.
- Reset values: front_bank=0, swap_pending=0, clear_busy=0, rd_valid=0, R1..B2=0, clear FSM in IDLE. wr_ready=1 from the first cycle after reset.
- Write path:
  - wr_ready = !clear_busy.
  - On accept, write wr_color to bank ~front_bank, half wr_y[YW-1], row wr_y[YW-2:0], column wr_x. The write is visible to reads of that bank on the next cycle.
- Read path:
  - On rd_en, read front_bank (as sampled that cycle) at {rd_row, rd_col} in both halves; bcm_phase is registered alongside.
  - The next cycle, rd_valid=1 and each output = channel bit [phase] of its half's pixel.
  - phase ≥ COLOR_BITS drives 0 on all six outputs.
  - When rd_en=0: rd_valid=0 next cycle and R1..B2 hold their last values.
- Clear FSM:
  - IDLE: on clear_req, latch clear_color, zero the address counter, go to CLEAR.
  - CLEAR: each cycle write the latched colour to both halves of the back bank at the counter, then increment. When counter = PANEL_W*PANEL_H/2-1, write and return to IDLE.
  - clear_busy=1 for exactly PANEL_W*PANEL_H/2 cycles, starting the cycle after clear_req.
  - clear_req while busy is ignored.
  - Writes stall (wr_ready=0) while busy; reads are unaffected (front bank).
- Swap:
  - swap_req sets swap_pending.
  - On frame_start with swap_pending=1 and clear_busy=0: toggle front_bank, clear swap_pending. front_bank changes the cycle after frame_start.
  - swap_req and frame_start in the same cycle: the swap is deferred to the next frame_start.
  - frame_start while clear_busy=1: swap deferred.
  - Repeated swap_req while pending: no additional effect.
- Boundaries:
  - The back bank changes only when front_bank toggles; a clear or write in progress never touches the displayed bank.
  - Reset mid-clear aborts the clear (partial fill remains) and returns front_bank to 0.

Optional Feature:
- Macro: HUB75_FB_CLEAR_EN.
- Defined: clear engine as above.
- Undefined: no FSM or counter; clear_req and clear_color ignored; clear_busy tied 0; wr_ready tied 1; swap never deferred by clear.

Test Plan:
- Reset, write (x=5,y=3,color=9'b101_010_111), swap_req, frame_start, rd_en row=3 col=5 phase=0 → next cycle rd_valid=1, R1=1 G1=0 B1=1; phase=1 → R1=0 G1=1 B1=1; phase=3 → all 0.
- Write y=35 x=0 color=9'b111_000_000 to back bank, swap, read row=3 col=0 phase=2 → R2=1, G2=B2=0; the top half is unaffected.
- Write the back bank without swap; read same address → the old front contents are returned; after frame_start with swap_pending → the new contents are returned; front_bank toggles exactly once.
- clear_req with clear_color=9'h1FF (64×64 panel) → clear_busy high 2048 cycles; wr_valid held high sees wr_ready=0 throughout; after swap every read with phase 0..2 gives all outputs 1.
- swap_req coincident with frame_start → no toggle; toggle on the following frame_start; frame_start during clear → deferred until the first frame_start after clear_busy falls.
- Assert reset at clear cycle 100 → clear_busy=0, front_bank=0, swap_pending=0 immediately; wr_ready=1 after release.

Source files
------------

// File: rtl/hub75_frame_buffer.sv
// Double-buffered HUB75 split-scan framebuffer with BCM bit-plane readout.
// Define HUB75_FB_CLEAR_EN to build the back-bank clear engine.
module hub75_frame_buffer #(
  parameter  int PANEL_W    = 64,
  parameter  int PANEL_H    = 64,
  parameter  int COLOR_BITS = 3,
  localparam int XW         = $clog2(PANEL_W),
  localparam int YW         = $clog2(PANEL_H),
  localparam int PW         = $clog2(COLOR_BITS + 1),
  localparam int CW         = 3 * COLOR_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [CW-1:0] wr_color,
  input  logic          clear_req,
  input  logic [CW-1:0] clear_color,
  output logic          clear_busy,
  input  logic          swap_req,
  output logic          swap_pending,
  output logic          front_bank,
  input  logic          frame_start,
  input  logic          rd_en,
  input  logic [YW-2:0] rd_row,
  input  logic [XW-1:0] rd_col,
  input  logic [PW-1:0] bcm_phase,
  output logic          rd_valid,
  output logic          R1,
  output logic          G1,
  output logic          B1,
  output logic          R2,
  output logic          G2,
  output logic          B2
);

  localparam int AW    = XW + YW - 1;
  localparam int DEPTH = PANEL_W * PANEL_H / 2;

  logic          r_front, r_pending;
  logic          w_busy;
  logic [AW-1:0] w_clr_addr;
  logic [CW-1:0] w_clr_data;

`ifdef HUB75_FB_CLEAR_EN
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]    r_state;
  logic [AW-1:0] r_cnt;
  logic [CW-1:0] r_clr_color;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_clr_color <= '0;
    end else if (r_state == S_IDLE) begin
      if (clear_req) begin
        r_clr_color <= clear_color;
        r_cnt       <= '0;
        r_state     <= S_CLEAR;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == AW'(DEPTH - 1)) r_state <= S_IDLE;
    end
  end

  assign w_busy     = (r_state == S_CLEAR);
  assign w_clr_addr = r_cnt;
  assign w_clr_data = r_clr_color;
`else
  logic w_unused_clr;
  assign w_unused_clr = ^{clear_req, clear_color};
  assign w_busy       = 1'b0;
  assign w_clr_addr   = '0;
  assign w_clr_data   = '0;
`endif

  assign clear_busy   = w_busy;
  assign wr_ready     = !w_busy;
  assign swap_pending = r_pending;
  assign front_bank   = r_front;

  // A swap_req landing with frame_start only arms the next frame's swap.
  logic w_do_swap;
  assign w_do_swap = frame_start & r_pending & ~w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_front   <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_do_swap) begin
      r_front   <= ~r_front;
      r_pending <= 1'b0;
    end else if (swap_req) begin
      r_pending <= 1'b1;
    end
  end

  logic          w_wr_acc;
  logic [AW-1:0] w_waddr, w_raddr;
  logic [CW-1:0] w_wdata;
  logic [3:0][CW-1:0] w_rd;

  assign w_wr_acc = wr_valid & wr_ready;
  assign w_waddr  = w_busy ? w_clr_addr : {wr_y[YW-2:0], wr_x};
  assign w_wdata  = w_busy ? w_clr_data : wr_color;
  assign w_raddr  = {rd_row, rd_col};

  // RAM index m = {bank, half}; only the back bank ever sees a write enable.
  genvar m;
  generate
    for (m = 0; m < 4; m++) begin : g_ram
      localparam logic BANK = 1'(m / 2);
      localparam logic HALF = 1'(m % 2);
      logic [CW-1:0] r_ram [DEPTH];
      logic          w_we;
      assign w_we = (BANK == ~r_front) &&
                    (w_busy || (w_wr_acc && (wr_y[YW-1] == HALF)));
      always_ff @(posedge clk) begin
        if (w_we) r_ram[w_waddr] <= w_wdata;
      end
      assign w_rd[m] = r_ram[w_raddr];
    end
  endgenerate

  logic          r_rd_valid;
  logic [CW-1:0] r_top, r_bot;
  logic [PW-1:0] r_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_top      <= '0;
      r_bot      <= '0;
      r_phase    <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_top   <= r_front ? w_rd[2] : w_rd[0];
        r_bot   <= r_front ? w_rd[3] : w_rd[1];
        r_phase <= bcm_phase;
      end
    end
  end

  function automatic logic f_bit(input logic [CW-1:0] pix, input int ch,
                                 input logic [PW-1:0] ph);
    logic [CW-1:0] s;
    s = pix >> (ch * COLOR_BITS + int'(ph));
    return (int'(ph) < COLOR_BITS) && s[0];
  endfunction

  assign rd_valid = r_rd_valid;
  assign R1 = f_bit(r_top, 2, r_phase);
  assign G1 = f_bit(r_top, 1, r_phase);
  assign B1 = f_bit(r_top, 0, r_phase);
  assign R2 = f_bit(r_bot, 2, r_phase);
  assign G2 = f_bit(r_bot, 1, r_phase);
  assign B2 = f_bit(r_bot, 0, r_phase);

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Directed bench for hub75_frame_buffer (64x64, 3 bits/channel); clear tests
// run only when HUB75_FB_CLEAR_EN is defined.
module tb_hub75_frame_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid, wr_ready;
  logic [5:0] wr_x, wr_y;
  logic [8:0] wr_color;
  logic       clear_req, clear_busy;
  logic [8:0] clear_color;
  logic       swap_req, swap_pending, front_bank, frame_start;
  logic       rd_en, rd_valid;
  logic [4:0] rd_row;
  logic [5:0] rd_col;
  logic [1:0] bcm_phase;
  logic       R1, G1, B1, R2, G2, B2;

  hub75_frame_buffer dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
    .swap_req(swap_req), .swap_pending(swap_pending), .front_bank(front_bank),
    .frame_start(frame_start),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .bcm_phase(bcm_phase),
    .rd_valid(rd_valid),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] row;
    logic [5:0] col;
    logic [1:0] ph;
    logic [2:0] top;
    logic [2:0] bot;
  } vec_t;

  vec_t tv[13];
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_front;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] x, input logic [5:0] y, input logic [8:0] c);
    wr_valid = 1'b1; wr_x = x; wr_y = y; wr_color = c;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic swap_now();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_pending_set", swap_pending, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_front = ~exp_front;
    chk("front_after_swap", front_bank, exp_front);
    chk("pending_cleared", swap_pending, 0);
  endtask

  task automatic run_tv(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rd_en = 1'b1; rd_row = tv[i].row; rd_col = tv[i].col; bcm_phase = tv[i].ph;
      tick();
      rd_en = 1'b0;
      chk($sformatf("rd_valid[%0d]", i), rd_valid, 1);
      chk($sformatf("top_rgb[%0d]", i), {R1, G1, B1}, tv[i].top);
      chk($sformatf("bot_rgb[%0d]", i), {R2, G2, B2}, tv[i].bot);
    end
    tick();
    chk("rd_valid_drop", rd_valid, 0);
    chk("hold_top", {R1, G1, B1}, tv[hi].top);
    chk("hold_bot", {R2, G2, B2}, tv[hi].bot);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{5'd3,  6'd5,  2'd0, 3'b101, 3'b011};
    tv[1]  = '{5'd3,  6'd5,  2'd1, 3'b011, 3'b100};
    tv[2]  = '{5'd3,  6'd5,  2'd2, 3'b101, 3'b010};
    tv[3]  = '{5'd3,  6'd5,  2'd3, 3'b000, 3'b000};
    tv[4]  = '{5'd3,  6'd0,  2'd0, 3'b010, 3'b001};
    tv[5]  = '{5'd3,  6'd0,  2'd2, 3'b010, 3'b001};
    tv[6]  = '{5'd3,  6'd0,  2'd2, 3'b010, 3'b001};
    tv[7]  = '{5'd3,  6'd0,  2'd2, 3'b111, 3'b100};
    tv[8]  = '{5'd3,  6'd0,  2'd0, 3'b000, 3'b100};
    tv[9]  = '{5'd0,  6'd0,  2'd0, 3'b111, 3'b111};
    tv[10] = '{5'd31, 6'd63, 2'd1, 3'b111, 3'b111};
    tv[11] = '{5'd3,  6'd5,  2'd2, 3'b111, 3'b111};
    tv[12] = '{5'd16, 6'd40, 2'd3, 3'b000, 3'b000};

    reset = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clear_req = 1'b0; clear_color = '0; swap_req = 1'b0; frame_start = 1'b0;
    rd_en = 1'b0; rd_row = '0; rd_col = '0; bcm_phase = '0;
    exp_front = 1'b0;
    tick(); tick();
    chk("rst_front", front_bank, 0);
    chk("rst_pending", swap_pending, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_outs", {R1, G1, B1, R2, G2, B2}, 0);
    reset = 1'b0;
    tick();
    chk("rdy_after_rst", wr_ready, 1);

    // Round 1: fill bank 1, swap it to the front, read bit planes.
    wr(6'd5, 6'd3,  9'b101_010_111);
    wr(6'd0, 6'd3,  9'b000_111_000);
    wr(6'd5, 6'd35, 9'b010_101_001);
    wr(6'd0, 6'd35, 9'b000_000_111);
    swap_now();
    run_tv(0, 5);

    // Round 2: back-bank writes stay hidden until the swap.
    wr(6'd0, 6'd3,  9'b110_110_110);
    wr(6'd0, 6'd35, 9'b111_000_000);
    run_tv(6, 6);
    swap_now();
    run_tv(7, 8);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("no_swap_unarmed", front_bank, exp_front);

    // swap_req coincident with frame_start only arms the swap.
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
    chk("coinc_no_toggle", front_bank, exp_front);
    chk("coinc_pending", swap_pending, 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    exp_front = ~exp_front;
    chk("coinc_next_toggle", front_bank, exp_front);

`ifdef HUB75_FB_CLEAR_EN
    begin
      int busy_cnt, rdy_bad, guard;
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      clear_color = 9'h1FF; clear_req = 1'b1;
      tick();
      clear_req = 1'b0; clear_color = '0;
      chk("clear_busy_start", clear_busy, 1);
      busy_cnt = 0; rdy_bad = 0; guard = 0;
      wr_valid = 1'b1; wr_x = 6'd5; wr_y = 6'd3; wr_color = '0;
      while (clear_busy && guard < 3000) begin
        busy_cnt++;
        if (wr_ready) rdy_bad++;
        clear_req   = (guard == 10);
        frame_start = (guard == 500);
        tick();
        guard++;
      end
      clear_req = 1'b0; frame_start = 1'b0; wr_valid = 1'b0;
      chk("clear_busy_cycles", busy_cnt, 2048);
      chk("stall_during_clear", rdy_bad, 0);
      chk("swap_deferred", front_bank, exp_front);
      chk("pending_kept", swap_pending, 1);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      exp_front = ~exp_front;
      chk("swap_after_clear", front_bank, exp_front);
      run_tv(9, 12);
    end
`else
    clear_color = 9'h1FF; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("noclr_busy", clear_busy, 0);
    chk("noclr_ready", wr_ready, 1);
    swap_now();
`endif

    // Reset in mid-flight returns front/pending/busy to idle immediately.
    if (!exp_front) swap_now();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
`ifdef HUB75_FB_CLEAR_EN
    clear_req = 1'b1; clear_color = 9'h0AA; tick(); clear_req = 1'b0;
    repeat (99) tick();
    chk("busy_before_rst", clear_busy, 1);
`endif
    chk("front_before_rst", front_bank, 1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", clear_busy, 0);
    chk("midrst_front", front_bank, 0);
    chk("midrst_pending", swap_pending, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_ready", wr_ready, 1);
    chk("midrst_busy_after", clear_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
